// File: rtl/swin_linebuf.sv
// swin_linebuf: sliding-window line buffer. Buffers WIN_ROWS-1 previous lines
// and, for every accepted input word, emits one window column holding the
// same column of the current line and the WIN_ROWS-1 lines above it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   line_words, frame_rows     frame geometry, sampled on frame_start
//   frame_start                single-cycle frame start / abort pulse
//   pix_data_in, data_in_vld, data_in_rdy       input word stream
//   pix_data_out, data_out_vld, data_out_rdy    window column stream
//                              (slice k = line r-k, slice 0 = newest)
//   frame_done                 single-cycle pulse after the last output
//
// Optional feature: define SWIN_ZERO_PAD_EN to emit outputs from row 0 with
// the not-yet-existing lines above the frame forced to zero.
module swin_linebuf #(
   parameter int unsigned PIX_WIDTH     = 8,
   parameter int unsigned PIX_PER_CYC   = 16,
   parameter int unsigned WIN_ROWS      = 3,
   parameter int unsigned LW_ADDR_WIDTH = 6
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [LW_ADDR_WIDTH:0]                    line_words,
   input  logic [15:0]                               frame_rows,
   input  logic                                      frame_start,
   input  logic [PIX_WIDTH*PIX_PER_CYC-1:0]          pix_data_in,
   input  logic                                      data_in_vld,
   output logic                                      data_in_rdy,
   output logic [PIX_WIDTH*PIX_PER_CYC*WIN_ROWS-1:0] pix_data_out,
   output logic                                      data_out_vld,
   input  logic                                      data_out_rdy,
   output logic                                      frame_done
);

   localparam int unsigned WORD_W = PIX_WIDTH * PIX_PER_CYC;
   localparam int unsigned OUT_W  = WORD_W * WIN_ROWS;
   localparam int unsigned NBUF   = WIN_ROWS - 1;
   localparam int unsigned DEPTH  = 1 << LW_ADDR_WIDTH;
   localparam int unsigned IDX_W  = (NBUF > 1) ? $clog2(NBUF) : 1;
   localparam int unsigned CW     = LW_ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

   state_t             state, state_nxt;
   logic               done_nxt;
   logic [CW-1:0]      col, lw_q;
   logic [15:0]        row, fr_q;
   logic [IDX_W-1:0]   widx, rd_idx;
   logic [WORD_W-1:0]  mem [NBUF][DEPTH];
   logic [OUT_W-1:0]   window;
   logic               cfg_ok, active, accept, emit, restart;
   logic               last_col, last_row, to_stream;

   assign cfg_ok      = (line_words != '0) && (frame_rows != '0);
   assign active      = (state == FILL) || (state == STREAM);
   assign data_in_rdy = active && (!data_out_vld || data_out_rdy);
   assign accept      = data_in_vld && data_in_rdy;
   assign restart     = frame_start && ((state != IDLE) || cfg_ok);
   assign last_col    = (col == (lw_q - CW'(1)));
   assign last_row    = (row == (fr_q - 16'd1));
   assign to_stream   = ((32'(row) + 32'd1) >= 32'(NBUF));

`ifdef SWIN_ZERO_PAD_EN
   assign emit = active;
`else
   assign emit = (state == STREAM);
`endif

   // Line r-k lives in buffer (widx - k) mod NBUF; lines above the frame read as zero.
   always_comb begin
      window = '0;
      rd_idx = '0;
      window[WORD_W-1:0] = pix_data_in;
      for (int k = 1; k < int'(WIN_ROWS); k++) begin
         if (32'(widx) >= 32'(k))
            rd_idx = IDX_W'(32'(widx) - 32'(k));
         else
            rd_idx = IDX_W'(32'(widx) + NBUF - 32'(k));
         if (32'(row) >= 32'(k))
            window[k*WORD_W +: WORD_W] = mem[rd_idx][col[LW_ADDR_WIDTH-1:0]];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; frame_start anywhere outside IDLE aborts and restarts.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start && cfg_ok) state_nxt = FILL;
         end
         FILL, STREAM: begin
            if (frame_start)
               state_nxt = cfg_ok ? FILL : IDLE;
            else if (accept && last_col) begin
               if (last_row)       state_nxt = DRAIN;
               else if (to_stream) state_nxt = STREAM;
            end
         end
         DRAIN: begin
            if (frame_start)
               state_nxt = cfg_ok ? FILL : IDLE;
            else if (!data_out_vld || data_out_rdy) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters, configuration capture and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col          <= '0;
         row          <= '0;
         widx         <= '0;
         lw_q         <= '0;
         fr_q         <= '0;
         data_out_vld <= 1'b0;
         pix_data_out <= '0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= done_nxt;
         if (restart) begin
            if (cfg_ok) begin
               lw_q <= line_words;
               fr_q <= frame_rows;
            end
            col          <= '0;
            row          <= '0;
            widx         <= '0;
            data_out_vld <= 1'b0;
            pix_data_out <= '0;
         end else begin
            if (accept) begin
               if (last_col) begin
                  col  <= '0;
                  row  <= row + 16'd1;
                  widx <= (32'(widx) == NBUF - 1) ? '0 : widx + IDX_W'(1);
               end else begin
                  col <= col + CW'(1);
               end
            end
            if (accept && emit) begin
               data_out_vld <= 1'b1;
               pix_data_out <= window;
            end else if (data_out_rdy) begin
               data_out_vld <= 1'b0;
            end
         end
      end
   end

   // Line buffer RAM (not reset); always written into the current rotation slot.
   always_ff @(posedge clk) begin
      if (accept && !restart)
         mem[widx][col[LW_ADDR_WIDTH-1:0]] <= pix_data_in;
   end

endmodule
